irq_arbiter16: RTL and testbench
================================

IRQ_ARBITER16 -- requirements
Module: irq_arbiter16

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port en, input, 1 bit: arbitration enable; edge capture continues when en=0.
REQ-004 The block SHALL have port irq, input, 16 bits: raw interrupt request lines, rising-edge sensitive.
REQ-005 The block SHALL have port mask_wr, input, 1 bit: load strobe for the mask register.
REQ-006 The block SHALL have port mask_in, input, 16 bits: new mask value; 1 = source masked.
REQ-007 The block SHALL have port ack, input, 1 bit: consumer acknowledge of the current grant.
REQ-008 The block SHALL have port gnt, output, 16 bits: registered one-hot grant, feeding the downstream 16-to-4 encoder.
REQ-009 The block SHALL have port gnt_valid, output, 1 bit: gnt holds a live grant.
REQ-010 The block SHALL have port pending, output, 16 bits: registered sticky pending flags.

Function
REQ-011 irq SHALL be registered into irq_q each cycle; pending[i] SHALL set on the edge where irq[i]=1 and irq_q[i]=0.
REQ-012 pending bits SHALL be sticky until cleared by an accepted ack of that bit; the mask SHALL NOT clear pending.
REQ-013 The eligible vector SHALL be pending & ~mask.
REQ-014 FSM states SHALL be IDLE and HOLD only.
REQ-015 IDLE -> HOLD SHALL occur on an edge where en=1 and eligible != 0; on that edge, gnt loads a one-hot winner and gnt_valid=1.
REQ-016 First grant latency SHALL be one cycle after pending sets, i.e. gnt_valid is high two edges after irq is first sampled high.
REQ-017 In HOLD, gnt SHALL stay constant, independent of en, mask writes and new pending bits.
REQ-018 An ack sampled high in HOLD SHALL, on that edge, clear the pending bit matching gnt, set gnt=0 and gnt_valid=0, return to IDLE, and update the priority pointer.
REQ-019 An ack while in IDLE SHALL be ignored.
REQ-020 Back-to-back grants SHALL be separated by exactly one IDLE cycle.
REQ-021 Round-robin: after acking bit k, search SHALL start at bit (k+1) mod 16, ascending, wrapping 15 -> 0.
REQ-022 If a new rising edge on bit k coincides with the ack edge of bit k, pending[k] SHALL remain 1.
REQ-023 mask_wr=1 SHALL load mask_in on that edge; the new mask affects eligibility from the next cycle.
REQ-024 gnt SHALL never have more than one bit set; gnt=0 whenever gnt_valid=0.

Reset
REQ-025 While rst_n=0: gnt=16'h0000, gnt_valid=0, pending=16'h0000, irq_q=16'h0000, mask=16'hFFFF, pointer=0, state=IDLE.
REQ-026 Reset asserted in HOLD SHALL drop the grant immediately, with no pending bit retained.
REQ-027 The first edge after rst_n deasserts SHALL sample irq normally; a line already high SHALL register as a rising edge.

Configuration
REQ-028 With IRQ_ARB_FIXED_PRIO_EN defined, the pointer SHALL be removed and the lowest-index eligible bit always wins.
REQ-029 Without IRQ_ARB_FIXED_PRIO_EN, round-robin per REQ-021 SHALL apply.

Verification
REQ-030 Reset, write mask=16'h0000, irq=16'h0004 -> pending=16'h0004 at edge E, gnt=16'h0004 and gnt_valid=1 at E+1; ack -> gnt=0, pending=0.
REQ-031 Round-robin: pending bits 1, 5 and 15 set, mask=0 -> grants 1, 5, 15 in order; then new irq on bits 1 and 15 -> 1 before 15 (wrap); with IRQ_ARB_FIXED_PRIO_EN, 1 is always first.
REQ-032 mask=16'hFFFE, irq on bits 0 and 3 -> only bit 0 granted; then mask write 16'h0000 -> bit 3 granted; pending[3] held throughout.
REQ-033 In HOLD on bit 2, pulse irq[2] low then high timed so the rising edge lands on the ack edge -> pending[2]=1 after ack and bit 2 is re-granted.
REQ-034 en=0 with pending=16'h0010 -> no grant; en=1 -> gnt=16'h0010 one cycle later; rst_n pulse in HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/irq_arbiter16.sv
// 16-source edge-capturing interrupt arbiter with a registered one-hot grant held until ack.
// Round-robin by default; define IRQ_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module irq_arbiter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] irq,
    input  logic        mask_wr,
    input  logic [15:0] mask_in,
    input  logic        ack,
    output logic [15:0] gnt,
    output logic        gnt_valid,
    output logic [15:0] pending
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] irq_q;
    logic [15:0] mask;
    logic [15:0] rise;
    logic [15:0] eligible;
    logic [15:0] clr;
    logic [15:0] pending_next;
    logic [3:0]  start;
    logic [3:0]  cand;
    logic [3:0]  win_idx;
    logic        grant_now;
    logic        ack_now;

    assign rise     = irq & ~irq_q;
    assign eligible = pending & ~mask;

    // A new rising edge on the acked bit wins over the clear, so it is never lost.
    assign pending_next = (pending & ~clr) | rise;

`ifdef IRQ_ARB_FIXED_PRIO_EN
    assign start = 4'd0;
`else
    logic [3:0] ptr;
    logic [3:0] gnt_idx;

    assign start = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= 4'd0;
            gnt_idx <= 4'd0;
        end else begin
            if (grant_now)
                gnt_idx <= win_idx;
            if (ack_now)
                ptr <= gnt_idx + 4'd1;
        end
    end
`endif

    // Descending scan so the candidate closest to start is the one left in win_idx.
    always_comb begin
        win_idx = 4'd0;
        cand    = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            cand = start + 4'(i);
            if (eligible[cand])
                win_idx = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en && (eligible != 16'h0000)) next_state = HOLD;
            HOLD:    if (ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant_now = 1'b0;
        ack_now   = 1'b0;
        clr       = 16'h0000;
        case (state)
            IDLE: grant_now = en && (eligible != 16'h0000);
            HOLD: begin
                ack_now = ack;
                if (ack)
                    clr = gnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= 16'h0000;
            mask      <= 16'hFFFF;
            pending   <= 16'h0000;
            gnt       <= 16'h0000;
            gnt_valid <= 1'b0;
        end else begin
            irq_q   <= irq;
            pending <= pending_next;
            if (mask_wr)
                mask <= mask_in;
            if (grant_now) begin
                gnt       <= 16'h0001 << win_idx;
                gnt_valid <= 1'b1;
            end else if (ack_now) begin
                gnt       <= 16'h0000;
                gnt_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_irq_arbiter16.sv
// Directed self-checking bench for irq_arbiter16; expectations are hand-derived per scenario.
// Follows IRQ_ARB_FIXED_PRIO_EN to pick the expected winner where the two policies differ.
module tb_irq_arbiter16;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] irq;
    logic        mask_wr;
    logic [15:0] mask_in;
    logic        ack;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic [15:0] pending;

    int checkCount;
    int errorCount;

    irq_arbiter16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .irq       (irq),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Inputs change 1ns after a rising edge, so every check sees settled post-edge state.
    task automatic applyStimulus(input logic [15:0] i, input logic a, input logic e);
        irq = i;
        ack = a;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic writeMask(input logic [15:0] m);
        mask_wr = 1'b1;
        mask_in = m;
        applyStimulus(irq, 1'b0, en);
        mask_wr = 1'b0;
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        mask_wr = 1'b0;
        mask_in = 16'h0000;
        applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'h0000, 1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        irq     = 16'h0000;
        ack     = 1'b0;
        mask_wr = 1'b0;
        mask_in = 16'h0000;

        doReset();
        checkOutput("rst_gnt", 32'(gnt), 32'h0000);
        checkOutput("rst_valid", 32'(gnt_valid), 32'h0);
        checkOutput("rst_pending", 32'(pending), 32'h0000);

        // Basic single grant on bit 2
        writeMask(16'h0000);
        applyStimulus(16'h0004, 1'b0, 1'b1);
        checkOutput("basic_pend_E", 32'(pending), 32'h0004);
        checkOutput("basic_gnt_E", 32'(gnt), 32'h0000);
        applyStimulus(16'h0004, 1'b0, 1'b1);
        checkOutput("basic_gnt_E1", 32'(gnt), 32'h0004);
        checkOutput("basic_valid_E1", 32'(gnt_valid), 32'h1);
        applyStimulus(16'h0004, 1'b1, 1'b1);
        checkOutput("basic_ack_gnt", 32'(gnt), 32'h0000);
        checkOutput("basic_ack_valid", 32'(gnt_valid), 32'h0);
        checkOutput("basic_ack_pend", 32'(pending), 32'h0000);

        // Round-robin over bits 1, 5, 15
        doReset();
        writeMask(16'h0000);
        applyStimulus(16'h8022, 1'b0, 1'b1);
        checkOutput("rr_pend", 32'(pending), 32'h8022);
        applyStimulus(16'h8022, 1'b0, 1'b1);
        checkOutput("rr_g1", 32'(gnt), 32'h0002);
        applyStimulus(16'h8022, 1'b1, 1'b1);
        checkOutput("rr_pend_a1", 32'(pending), 32'h8020);
        checkOutput("rr_gap1", 32'(gnt_valid), 32'h0);
        applyStimulus(16'h8022, 1'b0, 1'b1);
        checkOutput("rr_g5", 32'(gnt), 32'h0020);
        applyStimulus(16'h8022, 1'b1, 1'b1);
        applyStimulus(16'h8022, 1'b0, 1'b1);
        checkOutput("rr_g15", 32'(gnt), 32'h8000);
        applyStimulus(16'h8022, 1'b1, 1'b1);
        checkOutput("rr_pend_empty", 32'(pending), 32'h0000);
        applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'h8002, 1'b0, 1'b1);
        applyStimulus(16'h8002, 1'b0, 1'b1);
        checkOutput("rr_wrap_g1", 32'(gnt), 32'h0002);
        applyStimulus(16'h8002, 1'b1, 1'b1);
        applyStimulus(16'h8002, 1'b0, 1'b1);
        checkOutput("rr_wrap_g15", 32'(gnt), 32'h8000);
        applyStimulus(16'h8002, 1'b1, 1'b1);

        // Re-raise bit 0 on its ack edge; bit 1 also pending, so policy decides the next winner
        applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'h0003, 1'b0, 1'b1);
        applyStimulus(16'h0003, 1'b0, 1'b1);
        checkOutput("pol_g0", 32'(gnt), 32'h0001);
        applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'h0001, 1'b1, 1'b1);
        checkOutput("pol_pend", 32'(pending), 32'h0003);
        applyStimulus(16'h0001, 1'b0, 1'b1);
`ifdef IRQ_ARB_FIXED_PRIO_EN
        checkOutput("pol_next", 32'(gnt), 32'h0001);
`else
        checkOutput("pol_next", 32'(gnt), 32'h0002);
`endif

        // Masking holds bit 3 pending until the mask opens
        doReset();
        writeMask(16'hFFFE);
        applyStimulus(16'h0009, 1'b0, 1'b1);
        applyStimulus(16'h0009, 1'b0, 1'b1);
        checkOutput("mask_g0", 32'(gnt), 32'h0001);
        applyStimulus(16'h0009, 1'b1, 1'b1);
        checkOutput("mask_pend_a", 32'(pending), 32'h0008);
        applyStimulus(16'h0009, 1'b0, 1'b1);
        applyStimulus(16'h0009, 1'b0, 1'b1);
        checkOutput("mask_blocked", 32'(gnt_valid), 32'h0);
        checkOutput("mask_pend_hold", 32'(pending), 32'h0008);
        writeMask(16'h0000);
        checkOutput("mask_wr_edge", 32'(gnt_valid), 32'h0);
        applyStimulus(16'h0009, 1'b0, 1'b1);
        checkOutput("mask_g3", 32'(gnt), 32'h0008);

        // Rising edge coinciding with the ack edge of the same bit
        doReset();
        writeMask(16'h0000);
        applyStimulus(16'h0004, 1'b0, 1'b1);
        applyStimulus(16'h0004, 1'b0, 1'b1);
        applyStimulus(16'h0000, 1'b0, 1'b1);
        checkOutput("coin_hold", 32'(gnt), 32'h0004);
        applyStimulus(16'h0004, 1'b1, 1'b1);
        checkOutput("coin_pend", 32'(pending), 32'h0004);
        checkOutput("coin_valid", 32'(gnt_valid), 32'h0);
        applyStimulus(16'h0004, 1'b0, 1'b1);
        checkOutput("coin_regrant", 32'(gnt), 32'h0004);

        // Enable gating, ack in IDLE, async reset in HOLD, reset release with irq high
        doReset();
        writeMask(16'h0000);
        en = 1'b0;
        applyStimulus(16'h0010, 1'b0, 1'b0);
        applyStimulus(16'h0010, 1'b1, 1'b0);
        checkOutput("en0_ack_idle", 32'(pending), 32'h0010);
        checkOutput("en0_nogrant", 32'(gnt_valid), 32'h0);
        applyStimulus(16'h0010, 1'b0, 1'b1);
        checkOutput("en1_gnt", 32'(gnt), 32'h0010);
        rst_n = 1'b0;
        #1;
        checkOutput("async_gnt", 32'(gnt), 32'h0000);
        checkOutput("async_valid", 32'(gnt_valid), 32'h0);
        checkOutput("async_pend", 32'(pending), 32'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(16'h0010, 1'b0, 1'b1);
        checkOutput("rel_pend", 32'(pending), 32'h0010);
        checkOutput("rel_masked", 32'(gnt_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
